// File: rtl/load_balance_tracker_if.sv
// Bus between the load tracker and its environment (job source, completion
// reporter, four-way minimum finder). The tracker uses the slave modport.
interface load_balance_tracker_if;
   logic       job_valid;
   logic       job_ready;
   logic [3:0] mini;
   logic       assign_valid;
   logic [1:0] assign_idx;
   logic       done_valid;
   logic [1:0] done_idx;
   logic [2:0] nums1;
   logic [2:0] nums2;
   logic [2:0] nums3;
   logic [2:0] nums4;
   logic       err_underflow;

   modport slave (
      input  job_valid, mini, done_valid, done_idx,
      output job_ready, assign_valid, assign_idx,
             nums1, nums2, nums3, nums4, err_underflow
   );

   modport master (
      output job_valid, mini, done_valid, done_idx,
      input  job_ready, assign_valid, assign_idx,
             nums1, nums2, nums3, nums4, err_underflow
   );
endinterface

// File: rtl/load_balance_tracker.sv
// Four-entry load tracker closing the loop with a registered minimum finder.
// Optional LOAD_TRACK_STATS_EN adds jobs_total / peak_load statistics ports.

module load_balance_tracker_entry (
   input  logic       clk,
   input  logic       rstn,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [2:0] load_o,
   output logic [2:0] load_nxt_o
);
   logic [2:0] load_q, load_d;

   // Parent only raises inc below the ceiling and dec above zero.
   always_comb begin
      load_d = load_q;
      if (inc_i && !dec_i)      load_d = load_q + 3'd1;
      else if (dec_i && !inc_i) load_d = load_q - 3'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) load_q <= 3'd0;
      else       load_q <= load_d;
   end

   assign load_o     = load_q;
   assign load_nxt_o = load_d;
endmodule

module load_balance_tracker #(
   parameter int MAX_LOAD      = 7,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   load_balance_tracker_if.slave  bus
`ifdef LOAD_TRACK_STATS_EN
   ,
   output logic [7:0]             jobs_total,
   output logic [2:0]             peak_load
`endif
);
   localparam logic [2:0] MAX_L   = 3'(MAX_LOAD);
   localparam logic [2:0] SET_L   = 3'(SETTLE_CYCLES);
   localparam logic [2:0] SET_RST = 3'(SETTLE_CYCLES + 1);

   typedef enum logic {ST_READY, ST_SETTLE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [3:0][2:0] load, load_nxt;
   logic [3:0]      inc, dec;
   logic [1:0]      sel;
   logic            ready, xfer, done_ok, done_bad;
   logic            assign_valid_q;
   logic [1:0]      assign_idx_q;
   logic            err_q;
   logic            unused_mini_hi;

   assign sel            = bus.mini[1:0];
   assign unused_mini_hi = ^bus.mini[3:2];

   // Saturation check uses the pre-edge load, so a same-edge completion
   // on the selected entry cannot free a slot for this transfer.
   assign ready    = (state_q == ST_READY) && (load[sel] < MAX_L);
   assign xfer     = bus.job_valid && ready;
   assign done_ok  = bus.done_valid && (load[bus.done_idx] != 3'd0);
   assign done_bad = bus.done_valid && (load[bus.done_idx] == 3'd0);

   for (genvar g = 0; g < 4; g++) begin : g_entry
      assign inc[g] = xfer    && (sel == 2'(g));
      assign dec[g] = done_ok && (bus.done_idx == 2'(g));
      load_balance_tracker_entry u_entry (
         .clk        (clk),
         .rstn       (rstn),
         .inc_i      (inc[g]),
         .dec_i      (dec[g]),
         .load_o     (load[g]),
         .load_nxt_o (load_nxt[g])
      );
   end

   // Any accepted load change makes mini stale until the finder has
   // resampled nums and re-registered its answer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (xfer || done_ok) begin
         state_d = ST_SETTLE;
         cnt_d   = SET_L;
      end else if (state_q == ST_SETTLE) begin
         if (cnt_q <= 3'd1) begin
            state_d = ST_READY;
            cnt_d   = 3'd0;
         end else begin
            cnt_d   = cnt_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_SETTLE;
         cnt_q   <= SET_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         assign_valid_q <= 1'b0;
         assign_idx_q   <= 2'd0;
         err_q          <= 1'b0;
      end else begin
         assign_valid_q <= xfer;
         if (xfer)     assign_idx_q <= sel;
         if (done_bad) err_q        <= 1'b1;
      end
   end

   assign bus.job_ready     = ready;
   assign bus.assign_valid  = assign_valid_q;
   assign bus.assign_idx    = assign_idx_q;
   assign bus.nums1         = load[0];
   assign bus.nums2         = load[1];
   assign bus.nums3         = load[2];
   assign bus.nums4         = load[3];
   assign bus.err_underflow = err_q;

`ifdef LOAD_TRACK_STATS_EN
   logic [7:0] jobs_q;
   logic [2:0] peak_q, peak_d;

   // Peak follows next-state loads so it never lags the nums outputs.
   always_comb begin
      peak_d = peak_q;
      for (int i = 0; i < 4; i++)
         if (load_nxt[i] > peak_d) peak_d = load_nxt[i];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         jobs_q <= 8'd0;
         peak_q <= 3'd0;
      end else begin
         jobs_q <= jobs_q + 8'(xfer);
         peak_q <= peak_d;
      end
   end

   assign jobs_total = jobs_q;
   assign peak_load  = peak_q;
`else
   logic unused_load_nxt;
   assign unused_load_nxt = ^load_nxt;
`endif
endmodule
